// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment display driver.
//   HEX_SEG     : nibble -> active-low {g,f,e,d,c,b,a} segment code
//   AN_OFF      : all anodes off (active-low)
//   SEG_OFF     : all segments off (active-low)
//   CTRL_*_LSB  : field offsets inside the 16-bit control word
//   top_nib()   : index of the most significant non-zero nibble (0 if none)
package seg_pkg;

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int CTRL_W      = 16;
  localparam int CTRL_EN_LSB = 0;   // ctrl[7:0]  digit enable
  localparam int CTRL_DP_LSB = 8;   // ctrl[15:8] decimal point on

  // Entry n is the code for hex digit n (entry 15 is the leftmost element).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Digit 0 is returned for an all-zero value so it is never blanked.
  function automatic logic [2:0] top_nib(input logic [31:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 1; i < 8; i++)
      if (v[4*i +: 4] != 4'h0) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/seg_display_scan_timer.sv
// seg_scan_timer: per-digit prescaler and digit index counter.
//   clk, rst : clock, synchronous active-high reset
//   tick_o   : high in the last cycle of each digit slot (cnt == DIV-1)
//   idx_o    : digit currently being scanned, 0..7, advances on tick
module seg_scan_timer #(
  parameter int DIV = 25000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick_o,
  output logic [2:0] idx_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));
  assign idx_o  = idx_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (tick_o) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;   // natural 7 -> 0 wrap
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seg_display.sv
// seg_display: bus-writable eight-digit multiplexed seven-segment driver.
//   clk, rst  : clock, synchronous active-high reset
//   busaddr   : bus address; value reg at ADDR, control reg at ADDR+4
//   buswdata  : bus write data
//   buswe     : single-cycle write strobe
//   busdata   : combinational readback (0 for unmapped addresses)
//   an        : digit anodes, active-low, bit i = digit i (0 rightmost)
//   seg       : segments {g,f,e,d,c,b,a}, active-low
//   dp        : decimal point, active-low
// The written value sits in a shadow register and is copied to the
// displayed register only as digit 7 ends, so a frame never mixes values.
// Control writes act immediately.
// Build option SEG_LZB_EN: blank digits above the most significant
// non-zero nibble (digit 0 always shown).
module seg_display
  import seg_pkg::*;
#(
  parameter int          CLKRATE = 25000000,
  parameter int          SCANHZ  = 1000,
  parameter logic [31:0] ADDR    = 32'd411704
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] busaddr,
  input  logic [31:0] buswdata,
  input  logic        buswe,
  output logic [31:0] busdata,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DIV = CLKRATE / SCANHZ;

  logic              tick;
  logic [2:0]        idx;
  logic              sel_val, sel_ctl;
  logic [31:0]       shadow_q, shadow_d;
  logic [31:0]       disp_q, disp_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [7:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        nib;
  logic [7:0]        en, dpon;
  logic              lit;

  seg_scan_timer #(.DIV(DIV)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick),
    .idx_o  (idx)
  );

  assign sel_val = (busaddr == ADDR);
  assign sel_ctl = (busaddr == ADDR + 32'd4);

  always_comb begin
    busdata = 32'h0;
    if (sel_val)      busdata = shadow_q;
    else if (sel_ctl) busdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
  end

  // disp samples shadow_q (pre-write), so a write landing on the load
  // cycle is deferred to the next frame.
  always_comb begin
    shadow_d = shadow_q;
    ctrl_d   = ctrl_q;
    disp_d   = disp_q;
    if (buswe && sel_val) shadow_d = buswdata;
    if (buswe && sel_ctl) ctrl_d   = buswdata[CTRL_W-1:0];
    if (tick && idx == 3'd7) disp_d = shadow_q;
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    en    = ctrl_q[CTRL_EN_LSB +: 8];
    dpon  = ctrl_q[CTRL_DP_LSB +: 8];
    nib   = disp_q[{idx, 2'b00} +: 4];
    lit   = en[idx];
`ifdef SEG_LZB_EN
    if (idx > top_nib(disp_q)) lit = 1'b0;
`endif
    if (lit) begin
      an_d  = ~(8'h01 << idx);
      seg_d = HEX_SEG[nib];
      dp_d  = ~dpon[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= 32'h0;
      disp_q   <= 32'h0;
      ctrl_q   <= 16'h00FF;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      ctrl_q   <= ctrl_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display.sv
// Bench for seg_display with DIV = 8. Cycle k counts rising edges since
// reset release; after edge k the pins show digit ((k-1)/8)%8 and a frame
// load happens on edges k = 64, 128, ... . Writes scheduled at k are
// driven after edge k and captured on edge k+1.
module tb_seg_display;

  localparam logic [31:0] A = 32'd411704;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] busaddr = 32'h0;
  logic [31:0] buswdata = 32'h0;
  logic        buswe = 1'b0;
  logic [31:0] busdata;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg_display #(.CLKRATE(8), .SCANHZ(1), .ADDR(A)) dut (
    .clk(clk), .rst(rst), .busaddr(busaddr), .buswdata(buswdata),
    .buswe(buswe), .busdata(busdata), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    bit          rb;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } chk_t;

  typedef struct {
    int          k;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  chk_t ck_q[$];
  wr_t  wr_q[$];
  int   k = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] hx(input int n);
    logic [15:0][6:0] t;
    t = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
         7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    return t[n];
  endfunction

  function automatic void ex(int kk, logic [7:0] a, logic [6:0] s, logic d);
    chk_t c;
    c.k = kk; c.rb = 1'b0; c.raddr = '0; c.rdata = '0; c.an = a; c.seg = s; c.dp = d;
    ck_q.push_back(c);
  endfunction

  function automatic void exrb(int kk, logic [31:0] ad, logic [31:0] dat);
    chk_t c;
    c.k = kk; c.rb = 1'b1; c.raddr = ad; c.rdata = dat; c.an = '0; c.seg = '0; c.dp = 1'b0;
    ck_q.push_back(c);
  endfunction

  function automatic void wr(int kk, logic [31:0] ad, logic [31:0] dat);
    wr_t w;
    w.k = kk; w.addr = ad; w.data = dat;
    wr_q.push_back(w);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%h exp=%h", nm, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int last);
    while (k < last) begin
      step();
      buswe = 1'b0;
      foreach (ck_q[i]) if (ck_q[i].k == k) begin
        if (ck_q[i].rb) begin
          busaddr = ck_q[i].raddr;
          #1;
          cmp($sformatf("busdata@%h", ck_q[i].raddr), busdata, ck_q[i].rdata);
        end else begin
          cmp("an",  {24'h0, an},  {24'h0, ck_q[i].an});
          cmp("seg", {25'h0, seg}, {25'h0, ck_q[i].seg});
          cmp("dp",  {31'h0, dp},  {31'h0, ck_q[i].dp});
        end
      end
      foreach (wr_q[i]) if (wr_q[i].k == k) begin
        busaddr  = wr_q[i].addr;
        buswdata = wr_q[i].data;
        buswe    = 1'b1;
      end
    end
    buswe = 1'b0;
  endtask

  initial begin
    logic [6:0] f2 [8];
    f2 = '{7'h0E, 7'h46, 7'h03, 7'h08, 7'h30, 7'h24, 7'h79, 7'h40};

    // ---- Run 1 schedule ----
    for (int i = 0; i < 8; i++) ex(1 + 8*i, ~(8'h01 << i), 7'h40, 1'b1);
    ex(8, 8'hFE, 7'h40, 1'b1);
    exrb(2, A + 32'd4, 32'h0000_00FF);
    exrb(2, A, 32'h0);
    wr(20, A, 32'h0123_ABCF);
    exrb(21, A, 32'h0123_ABCF);
    ex(25, 8'hF7, 7'h40, 1'b1);            // old value still shown
    ex(64, 8'h7F, 7'h40, 1'b1);
    for (int i = 0; i < 8; i++) ex(65 + 8*i, ~(8'h01 << i), f2[i], 1'b1);
    ex(65, 8'hFE, hx(15), 1'b1);
    wr(128, A + 32'd4, 32'hFFFF_0201);     // upper half ignored
    exrb(129, A + 32'd4, 32'h0000_0201);
    ex(129, 8'hFE, 7'h0E, 1'b1);
    ex(130, 8'hFE, 7'h0E, 1'b1);
    ex(137, 8'hFF, 7'h7F, 1'b1);           // disabled digit, dp stays off
    ex(185, 8'hFF, 7'h7F, 1'b1);
    wr(140, A + 32'd8, 32'hDEAD_BEEF);     // unmapped
    exrb(141, A, 32'h0123_ABCF);
    exrb(141, A + 32'd8, 32'h0);
    exrb(141, A + 32'd4, 32'h0000_0201);
    ex(193, 8'hFE, 7'h0E, 1'b1);
    wr(194, A + 32'd4, 32'h0000_0101);
    ex(195, 8'hFE, 7'h0E, 1'b1);
    ex(196, 8'hFE, 7'h0E, 1'b0);           // dp on without frame delay
    wr(255, A, 32'h0000_0005);             // lands on the frame-load edge
    exrb(256, A, 32'h0000_0005);
    ex(257, 8'hFE, 7'h0E, 1'b0);           // old value for one more frame
    ex(265, 8'hFF, 7'h7F, 1'b1);
    ex(321, 8'hFE, 7'h12, 1'b0);           // new value next frame

    // ---- Reset state ----
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_an",  {24'h0, an},  32'hFF);
    cmp("rst_seg", {25'h0, seg}, 32'h7F);
    cmp("rst_dp",  {31'h0, dp},  32'h1);
    busaddr = A + 32'd4; #1;
    cmp("rst_ctrl", busdata, 32'h0000_00FF);
    busaddr = A;
    rst = 1'b0;
    k = 0;
    run_to(330);

    // ---- Reset mid-frame ----
    rst = 1'b1;
    @(posedge clk); #1;
    cmp("mrst_an",  {24'h0, an},  32'hFF);
    cmp("mrst_seg", {25'h0, seg}, 32'h7F);
    cmp("mrst_dp",  {31'h0, dp},  32'h1);
    busaddr = A; #1;
    cmp("mrst_shadow", busdata, 32'h0);
    busaddr = A + 32'd4; #1;
    cmp("mrst_ctrl", busdata, 32'h0000_00FF);
    rst = 1'b0;
    k = 0;

    // ---- Run 2: blanking behaviour ----
    ck_q.delete();
    wr_q.delete();
    ex(1, 8'hFE, 7'h40, 1'b1);             // disp cleared, no partial load
    ex(9, 8'hFD, 7'h40, 1'b1);
    wr(2, A, 32'h0000_0050);
    ex(65, 8'hFE, 7'h40, 1'b1);
    ex(73, 8'hFD, 7'h12, 1'b1);
    for (int i = 2; i < 8; i++) begin
`ifdef SEG_LZB_EN
      ex(65 + 8*i, 8'hFF, 7'h7F, 1'b1);
`else
      ex(65 + 8*i, ~(8'h01 << i), 7'h40, 1'b1);
`endif
    end
    wr(70, A, 32'h0);
    ex(129, 8'hFE, 7'h40, 1'b1);           // digit 0 never blanked
`ifdef SEG_LZB_EN
    ex(137, 8'hFF, 7'h7F, 1'b1);
    ex(185, 8'hFF, 7'h7F, 1'b1);
`else
    ex(137, 8'hFD, 7'h40, 1'b1);
    ex(185, 8'h7F, 7'h40, 1'b1);
`endif
    run_to(190);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
